// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for the 8-entry FIFO write-arbitration controller.
// Optional build macro used by this slice: FIFO_RR_ARB_EN (round-robin arbitration).
package fifo_ctrl_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_WIDTH = 3;

    // Which requester owns the memory write port this cycle.
    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_t;

    // Pointer with one extra wrap bit above the memory address bits.
    typedef logic [ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/fifo_rr_arbiter.sv
// Two-way write-port grant logic.
// With FIFO_RR_ARB_EN defined the grant rotates using a last_grant register;
// without it req0 has fixed priority and no state is kept.
module fifo_rr_arbiter
    import fifo_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req0_valid,
    input  logic   req1_valid,
    input  logic   wr_accept,
    output grant_t grant
);

`ifdef FIFO_RR_ARB_EN
    grant_t last_grant_q;
    grant_t last_grant_d;

    // Grant the lone requester, or on contention the one not served last.
    always_comb begin
        grant = GRANT_REQ0;
        if (req0_valid && req1_valid) begin
            grant = (last_grant_q == GRANT_REQ1) ? GRANT_REQ0 : GRANT_REQ1;
        end else if (req1_valid) begin
            grant = GRANT_REQ1;
        end
        // Only a write that actually lands moves the rotation forward.
        last_grant_d = wr_accept ? grant : last_grant_q;
    end

    // Reset to REQ1 so that req0 wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_REQ1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    logic unused_arb_inputs;

    // Fixed priority: req1 only wins when req0 is idle.
    always_comb begin
        grant = GRANT_REQ0;
        if (req1_valid && !req0_valid) begin
            grant = GRANT_REQ1;
        end
    end

    assign unused_arb_inputs = clk ^ rst ^ wr_accept;
`endif

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// FIFO controller for an external 8-entry async-read memory: arbitrates two
// write requesters onto the single write port, owns the wrap-bit pointers and
// status flags, and presents the head word through a registered valid/ready stage.
// Optional build macro: FIFO_RR_ARB_EN (round-robin instead of fixed priority).
//
// Handshake: a word moves on any rising edge where valid and ready are both 1.
// reqN_ready is combinational from the grant and the current full flag; the
// requester must hold valid/data until it sees ready. rd_data is held stable
// while rd_valid is 1 and rd_ready is 0.
module fifo_wr_arb_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_THR = 6
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic                  mem_w_clken,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);
    import fifo_ctrl_pkg::*;

    localparam int                PW        = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = PW'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF_THR    = PW'(ALMOST_FULL_THR);

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    grant_t grant;
    logic   wr_accept;
    logic   rd_load;

    fifo_rr_arbiter u_arb (
        .clk        (w_clk),
        .rst        (w_rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .wr_accept  (wr_accept),
        .grant      (grant)
    );

    // Status is decoded from the registered pointers only, so a load in the
    // same cycle never frees a slot for a write until the following cycle.
    always_comb begin
        fifo_count  = wr_ptr_q - rd_ptr_q;
        empty       = (fifo_count == '0);
        full        = (fifo_count == DEPTH_CNT);
        almost_full = (fifo_count >= AF_THR);
    end

    // Write side: grant steers data, full gates every ready.
    always_comb begin
        wr_accept   = (req0_valid || req1_valid) && !full;
        req0_ready  = wr_accept && (grant == GRANT_REQ0);
        req1_ready  = wr_accept && (grant == GRANT_REQ1);
        mem_w_clken = wr_accept;
        mem_w_addr  = wr_ptr_q[ADDR_WIDTH-1:0];
        mem_w_data  = (grant == GRANT_REQ1) ? req1_data : req0_data;
        mem_r_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
    end

    // Next-state for pointers and the output register.
    always_comb begin
        rd_load    = !empty && (!rd_valid_q || rd_ready);
        wr_ptr_d   = wr_accept ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (rd_load) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_valid_d = 1'b1;
            rd_data_d  = mem_r_data;
        end else if (rd_ready && rd_valid_q) begin
            rd_valid_d = 1'b0;
        end
    end

    // State registers; reset drops all stored and in-flight words.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Bench for fifo_wr_arb_ctrl: external memory model, queue-based reference
// model, directed vector table, corner-case sequences and random traffic.
module tb_fifo_wr_arb_ctrl;

    logic       w_clk;
    logic       w_rst;
    logic       req0_valid, req1_valid, rd_ready;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, rd_valid;
    logic [7:0] rd_data;
    logic       mem_w_clken;
    logic [2:0] mem_w_addr, mem_r_addr;
    logic [7:0] mem_w_data, mem_r_data;
    logic [3:0] fifo_count;
    logic       full, empty, almost_full;

    int tests_run;
    int tests_failed;

    // ---------------- clock / reset ----------------
    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    fifo_wr_arb_ctrl dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .mem_w_clken (mem_w_clken),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .mem_r_addr  (mem_r_addr),
        .mem_r_data  (mem_r_data),
        .fifo_count  (fifo_count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    // External memory: write on clock edge, asynchronous read.
    logic [7:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    always @(posedge w_clk) if (mem_w_clken) mem[mem_w_addr] <= mem_w_data;
    assign mem_r_data = mem[mem_r_addr];

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];     // words held in memory, oldest first
    bit         m_ov;       // output register valid
    logic [7:0] m_od;       // output register data
    int         m_last;     // last granted requester (round-robin build)
    int         m_wr_n;     // total accepted writes since reset
    int         m_rd_n;     // total loads since reset
    bit         m_sync;
    logic [7:0] exp_q[$];   // scoreboard: every accepted word, in order
    logic [7:0] out_log[$]; // words actually consumed
    bit         last_r0, last_r1;

    function automatic int m_grant();
        if (req0_valid && req1_valid) begin
`ifdef FIFO_RR_ARB_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        if (req1_valid) return 1;
        return 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven (from the negedge).
    task automatic tick();
        int         g;
        bit         acc, ld;
        logic [7:0] wd;
        #1;
        g   = m_grant();
        acc = (req0_valid || req1_valid) && (m_q.size() < 8);
        ld  = (m_q.size() > 0) && (!m_ov || rd_ready);
        wd  = (g == 1) ? req1_data : req0_data;
        last_r0 = req0_ready;
        last_r1 = req1_ready;
        if (m_sync) begin
            chk("req0_ready", int'(req0_ready), int'(acc && g == 0));
            chk("req1_ready", int'(req1_ready), int'(acc && g == 1));
            chk("mem_w_clken", int'(mem_w_clken), int'(acc));
            if (acc) begin
                chk("mem_w_addr", int'(mem_w_addr), m_wr_n % 8);
                chk("mem_w_data", int'(mem_w_data), int'(wd));
            end
            chk("mem_r_addr", int'(mem_r_addr), m_rd_n % 8);
            chk("fifo_count", int'(fifo_count), m_q.size());
            chk("full", int'(full), int'(m_q.size() == 8));
            chk("empty", int'(empty), int'(m_q.size() == 0));
            chk("almost_full", int'(almost_full), int'(m_q.size() >= 6));
            chk("rd_valid", int'(rd_valid), int'(m_ov));
            if (m_ov) chk("rd_data", int'(rd_data), int'(m_od));
            if (!w_rst && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    chk("sb_order", int'(rd_data), int'(exp_q.pop_front()));
                end
                out_log.push_back(rd_data);
            end
        end
        @(posedge w_clk);
        if (w_rst) begin
            m_q.delete();
            exp_q.delete();
            m_ov   = 1'b0;
            m_od   = 8'h00;
            m_last = 1;
            m_wr_n = 0;
            m_rd_n = 0;
            m_sync = 1'b1;
        end else if (m_sync) begin
            if (ld) begin
                m_od = m_q.pop_front();
                m_ov = 1'b1;
                m_rd_n++;
            end else if (m_ov && rd_ready) begin
                m_ov = 1'b0;
            end
            if (acc) begin
                m_q.push_back(wd);
                exp_q.push_back(wd);
                m_wr_n++;
                m_last = g;
            end
        end
        @(negedge w_clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit rst, input bit v0, input logic [7:0] d0,
                         input bit v1, input logic [7:0] d1, input bit rr);
        w_rst      = rst;
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        rd_ready   = rr;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; bit v0; logic [7:0] d0; bit v1; logic [7:0] d1; bit rr; bit chk;
        bit e_r0; bit e_r1; bit e_ce; logic [2:0] e_wa; logic [3:0] e_cnt;
        bit e_empty; bit e_rv; logic [7:0] e_rd;
    } vec_t;

    function automatic vec_t mk(int rst, int v0, int d0, int v1, int d1, int rr, int ck,
                                int r0, int r1, int ce, int wa, int cnt, int emp, int rv, int rd);
        vec_t v;
        v.rst = rst[0]; v.v0 = v0[0]; v.d0 = d0[7:0]; v.v1 = v1[0]; v.d1 = d1[7:0];
        v.rr = rr[0]; v.chk = ck[0]; v.e_r0 = r0[0]; v.e_r1 = r1[0]; v.e_ce = ce[0];
        v.e_wa = wa[2:0]; v.e_cnt = cnt[3:0]; v.e_empty = emp[0]; v.e_rv = rv[0];
        v.e_rd = rd[7:0];
        return v;
    endfunction

    vec_t vt[11];

    initial begin
        int         acc_n;
        int         g_seq[$];
        logic [7:0] d0n, d1n, hold_d;
        logic [2:0] hold_a;
        tests_run    = 0;
        tests_failed = 0;
        m_sync = 1'b0; m_ov = 1'b0; m_od = 8'h00; m_last = 1; m_wr_n = 0; m_rd_n = 0;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        //          rst v0 d0    v1 d1    rr ck  r0 r1 ce wa cnt em rv rd
        vt[0]  = mk(1,  0, 0,    0, 0,    0, 0,  0, 0, 0, 0, 0,  1, 0, 0);
        vt[1]  = mk(1,  0, 0,    0, 0,    0, 1,  0, 0, 0, 0, 0,  1, 0, 0);
        vt[2]  = mk(0,  1, 'hA5, 0, 0,    1, 1,  1, 0, 1, 0, 0,  1, 0, 0);
        vt[3]  = mk(0,  0, 0,    0, 0,    1, 1,  0, 0, 0, 0, 1,  0, 0, 0);
        vt[4]  = mk(0,  0, 0,    0, 0,    1, 1,  0, 0, 0, 0, 0,  1, 1, 'hA5);
        vt[5]  = mk(0,  0, 0,    1, 'h3C, 1, 1,  0, 1, 1, 1, 0,  1, 0, 0);
        vt[6]  = mk(0,  0, 0,    0, 0,    1, 1,  0, 0, 0, 0, 1,  0, 0, 0);
        vt[7]  = mk(0,  0, 0,    0, 0,    0, 1,  0, 0, 0, 0, 0,  1, 1, 'h3C);
        vt[8]  = mk(0,  0, 0,    0, 0,    0, 1,  0, 0, 0, 0, 0,  1, 1, 'h3C);
        vt[9]  = mk(0,  0, 0,    0, 0,    1, 1,  0, 0, 0, 0, 0,  1, 1, 'h3C);
        vt[10] = mk(0,  0, 0,    0, 0,    1, 1,  0, 0, 0, 0, 0,  1, 0, 0);

        @(negedge w_clk);
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].rst, vt[i].v0, vt[i].d0, vt[i].v1, vt[i].d1, vt[i].rr);
            #1;
            if (vt[i].chk) begin
                chk($sformatf("vec%0d_req0_ready", i), int'(req0_ready), int'(vt[i].e_r0));
                chk($sformatf("vec%0d_req1_ready", i), int'(req1_ready), int'(vt[i].e_r1));
                chk($sformatf("vec%0d_clken", i), int'(mem_w_clken), int'(vt[i].e_ce));
                if (vt[i].e_ce) chk($sformatf("vec%0d_waddr", i), int'(mem_w_addr), int'(vt[i].e_wa));
                chk($sformatf("vec%0d_count", i), int'(fifo_count), int'(vt[i].e_cnt));
                chk($sformatf("vec%0d_empty", i), int'(empty), int'(vt[i].e_empty));
                chk($sformatf("vec%0d_full", i), int'(full), 0);
                chk($sformatf("vec%0d_rd_valid", i), int'(rd_valid), int'(vt[i].e_rv));
                if (vt[i].e_rv) chk($sformatf("vec%0d_rd_data", i), int'(rd_data), int'(vt[i].e_rd));
            end
            tick();
        end

        // ---- both requesters contending until full, consumer stalled ----
        do_reset();
        d0n = 8'h10; d1n = 8'h20; acc_n = 0;
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, 1'b1, d0n, 1'b1, d1n, 1'b0);
            tick();
            if (last_r0) begin g_seq.push_back(0); d0n++; acc_n++; end
            if (last_r1) begin g_seq.push_back(1); d1n++; acc_n++; end
        end
        // 8 words in memory plus one parked in the output register.
        chk("contend_accepts", acc_n, 9);
        for (int k = 0; k < g_seq.size() && k < 9; k++) begin
`ifdef FIFO_RR_ARB_EN
            chk($sformatf("contend_grant%0d", k), g_seq[k], k % 2);
`else
            chk($sformatf("contend_grant%0d", k), g_seq[k], 0);
`endif
        end
        chk("contend_full", int'(full), 1);
        chk("contend_count", int'(fifo_count), 8);
        chk("contend_almost_full", int'(almost_full), 1);
        chk("contend_stall_ready", int'(req0_ready | req1_ready), 0);

        // ---- from full, one read: write refused that cycle, taken next ----
        drive(1'b0, 1'b1, d0n, 1'b1, d1n, 1'b1);
        tick();
        chk("full_read_same_cycle_ready", int'(last_r0 | last_r1), 0);
        drive(1'b0, 1'b1, d0n, 1'b1, d1n, 1'b0);
        #1;
        chk("after_read_count", int'(fifo_count), 7);
`ifdef FIFO_RR_ARB_EN
        chk("after_read_grant_req1", int'(req1_ready), 1);
`else
        chk("after_read_grant_req0", int'(req0_ready), 1);
`endif
        tick();
        chk("refill_count", int'(fifo_count), 8);

        // ---- streaming 20 words through with the consumer always ready ----
        do_reset();
        out_log.delete();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
            tick();
            chk($sformatf("stream_accept%0d", i), int'(last_r0), 1);
            chk($sformatf("stream_count%0d", i), int'(fifo_count), 1);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("stream_out_n", out_log.size(), 20);
        for (int i = 0; i < out_log.size() && i < 20; i++) begin
            chk($sformatf("stream_out%0d", i), int'(out_log[i]), i);
        end

        // ---- output stage held while consumer stalls ----
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h88, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        hold_d = rd_data;
        hold_a = mem_r_addr;
        chk("hold_valid", int'(rd_valid), 1);
        chk("hold_first", int'(hold_d), 8'h77);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_rd_data", int'(rd_data), int'(hold_d));
            chk("hold_r_addr", int'(mem_r_addr), int'(hold_a));
        end

        // ---- reset with words stored ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 8'(8'h50 + i), 1'b0, 8'h00, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 8'h60, 1'b1, 8'h61, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'h60, 1'b1, 8'h61, 1'b0);
        #1;
        chk("rst_mid_empty", int'(empty), 1);
        chk("rst_mid_rd_valid", int'(rd_valid), 0);
        chk("rst_mid_count", int'(fifo_count), 0);
        chk("rst_first_grant_r0", int'(req0_ready), 1);
        chk("rst_first_grant_r1", int'(req1_ready), 0);
        tick();

        // ---- randomized traffic against the reference model ----
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 2) != 0), 8'($urandom),
                  ($urandom_range(0, 2) != 0), 8'($urandom),
                  (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
